// File: rtl/edge_input_conditioner_if.sv
// Signal bundle between the pad conditioner and its edge consumer.
// The conditioner side takes the master modport; the consumer/config side
// takes the slave modport.
interface edge_input_conditioner_if #(
   parameter int FILT_W = 4,
   parameter int PEND_W = 3
);
   logic              din;
   logic [FILT_W-1:0] filt_len;
   logic [1:0]        edge_mode;
   logic              level_out;
   logic              edge_valid;
   logic              edge_ready;
   logic [PEND_W-1:0] pending;
   logic              overflow;
   logic              ovf_clr;

   modport master (
      input  din, filt_len, edge_mode, edge_ready, ovf_clr,
      output level_out, edge_valid, pending, overflow
   );

   modport slave (
      output din, filt_len, edge_mode, edge_ready, ovf_clr,
      input  level_out, edge_valid, pending, overflow
   );
endinterface

// File: rtl/edge_input_conditioner.sv
// Raw pad input -> synchronizer -> glitch filter -> edge detector ->
// saturating pending-edge counter drained by a valid/ready consumer.
module edge_input_conditioner #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_W      = 4,
   parameter int PEND_W      = 3
) (
   input logic                    clk,
   input logic                    rst,
   edge_input_conditioner_if.master bus
);
   localparam logic [FILT_W-1:0] CNT_MAX  = '1;
   localparam logic [PEND_W-1:0] PEND_MAX = '1;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [FILT_W-1:0]      cnt;
   logic                   level;
   logic [PEND_W-1:0]      pend;
   logic                   ovf;

   logic                   upd;
   logic                   evt;
   logic                   accept;
   logic [PEND_W-1:0]      pend_nxt;
   logic                   ovf_set;

   assign s = sync_q[SYNC_STAGES-1];

   // Metastability chain; din enters at bit 0, s leaves at the top.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[SYNC_STAGES-2:0], bus.din};
   end

   // A level change commits only once s has disagreed for filt_len+1 cycles.
   // filt_len is used live, so lowering it below cnt commits at once.
   assign upd = (s != level) && (cnt >= bus.filt_len);

   // Filter counter and filtered level; cnt saturates rather than wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (s == level) begin
         cnt <= '0;
      end else if (upd) begin
         level <= s;
         cnt   <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + 1'b1;
      end
   end

   // mode[0] enables rising (new level 1), mode[1] enables falling.
   assign evt    = upd && (s ? bus.edge_mode[0] : bus.edge_mode[1]);
   assign accept = (pend != '0) && bus.edge_ready;

   // Pending count next-state; a full counter that cannot drain drops the edge.
   always_comb begin
      pend_nxt = pend;
      ovf_set  = 1'b0;
      if (evt && !accept) begin
         if (pend == PEND_MAX) ovf_set  = 1'b1;
         else                  pend_nxt = pend + 1'b1;
      end else if (!evt && accept) begin
         pend_nxt = pend - 1'b1;
      end
   end

   // Pending register and sticky overflow; a new drop beats a same-cycle clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend <= '0;
         ovf  <= 1'b0;
      end else begin
         pend <= pend_nxt;
         if (ovf_set)          ovf <= 1'b1;
         else if (bus.ovf_clr) ovf <= 1'b0;
      end
   end

   assign bus.level_out  = level;
   assign bus.pending    = pend;
   assign bus.edge_valid = (pend != '0);
   assign bus.overflow   = ovf;
endmodule

// File: tb/tb_edge_input_conditioner.sv
// Bench for edge_input_conditioner: a vector table of single din changes plus
// hand-written sequences for latency, glitch rejection, saturation and reset.
// Expected accepted edges sit in a scoreboard queue tagged with the cycle and
// direction they must appear in.
module tb_edge_input_conditioner;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   edge_input_conditioner_if #(.FILT_W(4), .PEND_W(3)) bus ();

   edge_input_conditioner #(.SYNC_STAGES(2), .FILT_W(4), .PEND_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int   cyc;
      logic rising;
   } exp_t;

   typedef struct {
      logic [3:0] filt;
      logic [1:0] mode;
      logic       din;
      int         hold;
      logic       exp_level;
      int         exp_edges;
      int         exp_lat;
   } vec_t;

   exp_t sb[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   int   pops   = 0;
   bit   mon_en = 1'b0;

   task automatic check(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock; returns at the following negedge after checking any accept.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (mon_en && bus.edge_valid && bus.edge_ready) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_edge", 1, 0);
         end else begin
            e = sb.pop_front();
            pops++;
            check("edge_cycle", cyc, e.cyc);
            check("edge_dir", bus.level_out, e.rising);
         end
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   vec_t vt[10];
   int   acc;
   int   c0;
   bit   glitch_bad;

   initial begin
      vt[0] = '{filt:4'd3,  mode:2'b01, din:1'b1, hold:12, exp_level:1'b1, exp_edges:1, exp_lat:6};
      vt[1] = '{filt:4'd3,  mode:2'b01, din:1'b0, hold:12, exp_level:1'b0, exp_edges:0, exp_lat:0};
      vt[2] = '{filt:4'd0,  mode:2'b11, din:1'b1, hold:8,  exp_level:1'b1, exp_edges:1, exp_lat:3};
      vt[3] = '{filt:4'd0,  mode:2'b11, din:1'b0, hold:8,  exp_level:1'b0, exp_edges:1, exp_lat:3};
      vt[4] = '{filt:4'd5,  mode:2'b10, din:1'b1, hold:12, exp_level:1'b1, exp_edges:0, exp_lat:0};
      vt[5] = '{filt:4'd5,  mode:2'b10, din:1'b0, hold:12, exp_level:1'b0, exp_edges:1, exp_lat:8};
      vt[6] = '{filt:4'd0,  mode:2'b00, din:1'b1, hold:8,  exp_level:1'b1, exp_edges:0, exp_lat:0};
      vt[7] = '{filt:4'd0,  mode:2'b00, din:1'b0, hold:8,  exp_level:1'b0, exp_edges:0, exp_lat:0};
      vt[8] = '{filt:4'd15, mode:2'b01, din:1'b1, hold:22, exp_level:1'b1, exp_edges:1, exp_lat:18};
      vt[9] = '{filt:4'd1,  mode:2'b10, din:1'b0, hold:8,  exp_level:1'b0, exp_edges:1, exp_lat:4};

      bus.din        = 1'b0;
      bus.filt_len   = 4'd3;
      bus.edge_mode  = 2'b01;
      bus.edge_ready = 1'b1;
      bus.ovf_clr    = 1'b0;

      // Reset state
      ticks(2);
      check("rst_level", bus.level_out, 0);
      check("rst_valid", bus.edge_valid, 0);
      check("rst_pending", bus.pending, 0);
      check("rst_overflow", bus.overflow, 0);
      rst = 1'b0;
      ticks(2);

      // Latency: filt_len=3 -> level_out exactly 6 clocks after first sample
      mon_en = 1'b1;
      pops = 0;
      bus.din = 1'b1;
      sb.push_back('{cyc:cyc + 6, rising:1'b1});
      ticks(5);
      check("lat_early_level", bus.level_out, 0);
      tick();
      check("lat_level", bus.level_out, 1);
      check("lat_valid", bus.edge_valid, 1);
      tick();
      check("lat_valid_1cyc", bus.edge_valid, 0);
      check("lat_pending", bus.pending, 0);
      check("lat_pops", pops, 1);

      // Return to level 0 silently
      bus.edge_mode = 2'b00;
      bus.filt_len  = 4'd0;
      bus.din       = 1'b0;
      ticks(8);

      // Glitch rejection: 3-cycle pulses never pass filt_len=3
      bus.filt_len  = 4'd3;
      bus.edge_mode = 2'b11;
      glitch_bad = 1'b0;
      for (int p = 0; p < 5; p++) begin
         bus.din = 1'b1;
         for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.level_out || bus.pending != 0) glitch_bad = 1'b1;
         end
         bus.din = 1'b0;
         for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.level_out || bus.pending != 0) glitch_bad = 1'b1;
         end
      end
      ticks(4);
      check("glitch_disturbed", glitch_bad, 0);
      check("glitch_level", bus.level_out, 0);
      check("glitch_pending", bus.pending, 0);

      // Vector table: one din change per record, ready held high
      for (int v = 0; v < 10; v++) begin
         pops = 0;
         bus.filt_len  = vt[v].filt;
         bus.edge_mode = vt[v].mode;
         bus.din       = vt[v].din;
         if (vt[v].exp_edges != 0)
            sb.push_back('{cyc:cyc + vt[v].exp_lat, rising:vt[v].din});
         ticks(vt[v].hold);
         check("vec_level", bus.level_out, vt[v].exp_level);
         check("vec_edges", pops, vt[v].exp_edges);
         check("vec_pending", bus.pending, 0);
      end

      // Saturation with a stalled consumer
      mon_en = 1'b0;
      bus.edge_ready = 1'b0;
      bus.filt_len   = 4'd0;
      bus.edge_mode  = 2'b11;
      for (int t = 0; t < 9; t++) begin
         bus.din = ~bus.din;
         ticks(4);
      end
      check("sat_pending", bus.pending, 7);
      check("sat_overflow", bus.overflow, 1);
      check("sat_valid", bus.edge_valid, 1);
      bus.edge_ready = 1'b1;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.edge_valid && bus.edge_ready) acc++;
         tick();
      end
      check("drain_accepts", acc, 7);
      check("drain_pending", bus.pending, 0);
      check("drain_valid", bus.edge_valid, 0);
      check("drain_overflow_sticky", bus.overflow, 1);
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      check("ovf_cleared", bus.overflow, 0);

      // Full counter: event and accept together, then overflow vs clear
      bus.edge_ready = 1'b0;
      for (int t = 0; t < 7; t++) begin
         bus.din = ~bus.din;
         ticks(4);
      end
      check("full_pending", bus.pending, 7);
      check("full_no_ovf", bus.overflow, 0);
      bus.din = ~bus.din;
      ticks(2);
      bus.edge_ready = 1'b1;
      tick();
      bus.edge_ready = 1'b0;
      check("full_accept_evt_pending", bus.pending, 7);
      check("full_accept_evt_ovf", bus.overflow, 0);
      ticks(2);
      bus.din = ~bus.din;
      ticks(2);
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      check("set_beats_clr", bus.overflow, 1);
      check("set_beats_clr_pending", bus.pending, 7);
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      check("clr_alone", bus.overflow, 0);
      bus.edge_ready = 1'b1;
      ticks(9);
      check("full_drained", bus.pending, 0);

      // Async reset mid-operation with din held high mid-filter
      bus.edge_ready = 1'b0;
      bus.edge_mode  = 2'b01;
      bus.filt_len   = 4'd0;
      bus.din        = 1'b0;
      ticks(4);
      for (int p = 0; p < 5; p++) begin
         bus.din = 1'b1;
         ticks(4);
         bus.din = 1'b0;
         ticks(4);
      end
      check("pre_rst_pending", bus.pending, 5);
      bus.filt_len = 4'd3;
      bus.din      = 1'b1;
      ticks(3);
      #2;
      rst = 1'b1;
      #1;
      check("arst_pending", bus.pending, 0);
      check("arst_valid", bus.edge_valid, 0);
      check("arst_level", bus.level_out, 0);
      check("arst_overflow", bus.overflow, 0);
      tick();
      rst = 1'b0;
      pops = 0;
      bus.edge_ready = 1'b1;
      mon_en = 1'b1;
      sb.push_back('{cyc:cyc + 6, rising:1'b1});
      ticks(12);
      check("post_rst_edges", pops, 1);
      check("post_rst_level", bus.level_out, 1);
      check("post_rst_pending", bus.pending, 0);
      check("sb_leftover", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end
endmodule
